id_stage: RTL and testbench

- RV32I instruction decode stage. Sits between instruction fetch and execute, directly upstream of the register-file read ports.
- Drives `rs1_addr`/`rs2_addr` combinationally from the incoming instruction and takes the returned operands.
- Generates the sign-extended immediate and control signals, then registers everything into a single ID/EX pipeline register.
- Supports a valid/ready handshake, flush, and load-use stall.

---
 rtl/id_stage_pkg.sv | 53 +++++
 rtl/id_stage_imm_gen.sv | 25 ++
 rtl/id_stage.sv | 211 +++++++++++++++++++++
 tb/tb_id_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared RV32I decode types: opcode, ALU operation and immediate format encodings,
// plus the funct3-to-ALU mapping used by OP and OP-IMM.
package id_stage_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_type_t;

   // alt selects SUB/SRA for funct3 000/101; callers only set it where that is legal.
   function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
      case (funct3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational RV32I immediate generator: picks the I/S/B/U/J field layout
// and sign-extends from instr[31].
module id_stage_imm_gen
   import id_stage_pkg::*;
(
   input  logic [31:0] i_instr,
   input  imm_type_t   i_imm_type,
   output logic [31:0] o_imm
);

   always_comb begin
      o_imm = '0;
      case (i_imm_type)
         IMM_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
         IMM_U:   o_imm = {i_instr[31:12], 12'b0};
         IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with a single ID/EX register, valid/ready handshake, flush and
// load-use stall. Define ID_WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [31:0]       if_instr,
   input  logic [PC_W-1:0]   if_pc,
   input  logic              flush,
   output logic [ADDR_W-1:0] rs1_addr,
   output logic [ADDR_W-1:0] rs2_addr,
   input  logic [WIDTH-1:0]  rs1_data,
   input  logic [WIDTH-1:0]  rs2_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [WIDTH-1:0]  wb_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [PC_W-1:0]   ex_pc,
   output logic [WIDTH-1:0]  ex_rs1_val,
   output logic [WIDTH-1:0]  ex_rs2_val,
   output logic [WIDTH-1:0]  ex_imm,
   output logic [ADDR_W-1:0] ex_rd_addr,
   output logic [3:0]        ex_alu_op,
   output logic              ex_alu_src_imm,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic              ex_jump,
   output logic              ex_illegal
);

   logic [6:0]              w_opcode;
   logic [2:0]              w_funct3;
   logic [6:0]              w_funct7;
   logic [ADDR_W-1:0]       w_rd;
   imm_type_t               w_imm_type;
   alu_op_t                 w_alu_op;
   logic                    w_src_imm, w_wr, w_mr, w_mw, w_br, w_jmp, w_ill;
   logic                    w_use1, w_use2, w_shift;
   logic [31:0]             w_imm_gen;
   logic [31:0]             w_imm32;
   logic signed [WIDTH-1:0] w_imm;
   logic [WIDTH-1:0]        w_rs1_val, w_rs2_val;
   logic                    w_load_use, w_capture;

   logic                    r_valid;
   logic [PC_W-1:0]         r_pc;
   logic [WIDTH-1:0]        r_rs1_val, r_rs2_val, r_imm;
   logic [ADDR_W-1:0]       r_rd;
   alu_op_t                 r_alu_op;
   logic                    r_src_imm, r_wr, r_mr, r_mw, r_br, r_jmp, r_ill;

   assign w_opcode = if_instr[6:0];
   assign w_rd     = if_instr[11:7];
   assign w_funct3 = if_instr[14:12];
   assign w_funct7 = if_instr[31:25];
   assign rs1_addr = if_instr[19:15];
   assign rs2_addr = if_instr[24:20];

   always_comb begin
      w_imm_type = IMM_I;
      w_alu_op   = ALU_ADD;
      w_src_imm  = 1'b0;
      w_wr       = 1'b0;
      w_mr       = 1'b0;
      w_mw       = 1'b0;
      w_br       = 1'b0;
      w_jmp      = 1'b0;
      w_ill      = 1'b0;
      w_use1     = 1'b0;
      w_use2     = 1'b0;
      w_shift    = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            w_imm_type = IMM_U; w_alu_op = ALU_PASS_B; w_src_imm = 1'b1; w_wr = 1'b1;
         end
         OPC_AUIPC: begin
            w_imm_type = IMM_U; w_src_imm = 1'b1; w_wr = 1'b1;
         end
         OPC_JAL: begin
            w_imm_type = IMM_J; w_src_imm = 1'b1; w_wr = 1'b1; w_jmp = 1'b1;
         end
         OPC_JALR: begin
            w_imm_type = IMM_I; w_src_imm = 1'b1; w_wr = 1'b1; w_jmp = 1'b1; w_use1 = 1'b1;
         end
         OPC_BRANCH: begin
            w_imm_type = IMM_B; w_br = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
            // Comparison flavour only; the branch unit resolves eq/ne/lt/ge from funct3.
            case (w_funct3[2:1])
               2'b10:   w_alu_op = ALU_SLT;
               2'b11:   w_alu_op = ALU_SLTU;
               default: w_alu_op = ALU_SUB;
            endcase
         end
         OPC_LOAD: begin
            w_imm_type = IMM_I; w_src_imm = 1'b1; w_wr = 1'b1; w_mr = 1'b1; w_use1 = 1'b1;
         end
         OPC_STORE: begin
            w_imm_type = IMM_S; w_src_imm = 1'b1; w_mw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
         end
         OPC_OP_IMM: begin
            w_imm_type = IMM_I; w_src_imm = 1'b1; w_wr = 1'b1; w_use1 = 1'b1;
            w_shift    = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
            w_alu_op   = alu_from_funct3(w_funct3,
                                         (w_funct3 == 3'b101) && (w_funct7 == 7'b0100000));
            if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000)
               w_ill = 1'b1;
            if (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)
               w_ill = 1'b1;
         end
         OPC_OP: begin
            w_wr = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
            w_alu_op = alu_from_funct3(w_funct3, w_funct7[5]);
            if (w_funct7 == 7'b0100000)
               w_ill = !((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
            else if (w_funct7 != 7'b0000000)
               w_ill = 1'b1;
         end
         default: w_ill = 1'b1;
      endcase
   end

   id_stage_imm_gen u_imm_gen (
      .i_instr    (if_instr),
      .i_imm_type (w_imm_type),
      .o_imm      (w_imm_gen)
   );

   assign w_imm32 = w_shift ? {27'b0, if_instr[24:20]} : w_imm_gen;
   assign w_imm   = WIDTH'($signed(w_imm32));

`ifdef ID_WB_BYPASS_EN
   assign w_rs1_val = (wb_en && wb_addr != '0 && wb_addr == rs1_addr) ? wb_data : rs1_data;
   assign w_rs2_val = (wb_en && wb_addr != '0 && wb_addr == rs2_addr) ? wb_data : rs2_data;
`else
   logic w_unused_wb;
   assign w_unused_wb = ^{wb_en, wb_addr, wb_data};
   assign w_rs1_val   = rs1_data;
   assign w_rs2_val   = rs2_data;
`endif

   // A load in ID/EX cannot feed its result to the very next instruction's operands.
   assign w_load_use = r_valid && r_mr && (r_rd != '0) &&
                       ((w_use1 && r_rd == rs1_addr) || (w_use2 && r_rd == rs2_addr));
   assign if_ready   = (!r_valid || ex_ready) && !w_load_use;
   assign w_capture  = if_valid && if_ready;

   // ID/EX pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_rs1_val <= '0;
         r_rs2_val <= '0;
         r_imm     <= '0;
         r_rd      <= '0;
         r_alu_op  <= ALU_ADD;
         r_src_imm <= 1'b0;
         r_wr      <= 1'b0;
         r_mr      <= 1'b0;
         r_mw      <= 1'b0;
         r_br      <= 1'b0;
         r_jmp     <= 1'b0;
         r_ill     <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_valid   <= 1'b1;
         r_pc      <= if_pc;
         r_rs1_val <= w_rs1_val;
         r_rs2_val <= w_rs2_val;
         r_imm     <= w_imm;
         r_rd      <= w_rd;
         r_alu_op  <= w_alu_op;
         r_src_imm <= w_src_imm;
         r_wr      <= w_wr && !w_ill && (w_rd != '0);
         r_mr      <= w_mr && !w_ill;
         r_mw      <= w_mw && !w_ill;
         r_br      <= w_br && !w_ill;
         r_jmp     <= w_jmp && !w_ill;
         r_ill     <= w_ill;
      end else if (ex_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign ex_valid       = r_valid;
   assign ex_pc          = r_pc;
   assign ex_rs1_val     = r_rs1_val;
   assign ex_rs2_val     = r_rs2_val;
   assign ex_imm         = r_imm;
   assign ex_rd_addr     = r_rd;
   assign ex_alu_op      = r_alu_op;
   assign ex_alu_src_imm = r_src_imm;
   assign ex_reg_write   = r_wr;
   assign ex_mem_read    = r_mr;
   assign ex_mem_write   = r_mw;
   assign ex_branch      = r_br;
   assign ex_jump        = r_jmp;
   assign ex_illegal     = r_ill;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: handshake, stall, flush, decode and operand capture.
// Expected values are hand-decoded from the instruction encodings.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, if_ready, flush;
   logic [31:0] if_instr, if_pc;
   logic [4:0]  rs1_addr, rs2_addr, wb_addr, ex_rd_addr;
   logic [31:0] rs1_data, rs2_data, wb_data;
   logic        wb_en, ex_valid, ex_ready;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [3:0]  ex_alu_op;
   logic        ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write;
   logic        ex_branch, ex_jump, ex_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .flush(flush),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
      .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] d1, input logic [31:0] d2);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
      rs1_data = d1;
      rs2_data = d2;
   endtask

   initial begin
      rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
      rs1_data = '0; rs2_data = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      ex_ready = 1'b1;
      tick(); tick();
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_ex_imm", ex_imm, 32'd0);
      check("rst_ex_pc", ex_pc, 32'd0);
      check("rst_reg_write", 32'(ex_reg_write), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_if_ready", 32'(if_ready), 32'd1);

      // ADDI x1,x0,5
      present(32'h00500093, 32'h100, 32'h0, 32'h55);
      #1;
      check("addi_rs1_addr", 32'(rs1_addr), 32'd0);
      check("addi_rs2_addr", 32'(rs2_addr), 32'd5);
      tick();
      check("addi_valid", 32'(ex_valid), 32'd1);
      check("addi_imm", ex_imm, 32'd5);
      check("addi_rd", 32'(ex_rd_addr), 32'd1);
      check("addi_src_imm", 32'(ex_alu_src_imm), 32'd1);
      check("addi_reg_write", 32'(ex_reg_write), 32'd1);
      check("addi_alu_op", 32'(ex_alu_op), 32'd0);
      check("addi_pc", ex_pc, 32'h100);

      // Back-pressure: ADD x5,x6,x7 waits while execute is busy
      ex_ready = 1'b0;
      present(32'h007302B3, 32'h104, 32'hAAAA0001, 32'hBBBB0002);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("hold_if_ready", 32'(if_ready), 32'd0);
         tick();
         check("hold_valid", 32'(ex_valid), 32'd1);
         check("hold_imm", ex_imm, 32'd5);
         check("hold_rd", 32'(ex_rd_addr), 32'd1);
         check("hold_pc", ex_pc, 32'h100);
      end
      ex_ready = 1'b1;
      #1;
      check("release_if_ready", 32'(if_ready), 32'd1);
      tick();
      check("add_rd", 32'(ex_rd_addr), 32'd5);
      check("add_src_imm", 32'(ex_alu_src_imm), 32'd0);
      check("add_rs1_val", ex_rs1_val, 32'hAAAA0001);
      check("add_rs2_val", ex_rs2_val, 32'hBBBB0002);
      check("add_pc", ex_pc, 32'h104);

      // LW x2,0(x1) then ADD x3,x2,x2: one bubble
      present(32'h0000A103, 32'h108, 32'h0, 32'h0);
      tick();
      check("lw_mem_read", 32'(ex_mem_read), 32'd1);
      check("lw_reg_write", 32'(ex_reg_write), 32'd1);
      present(32'h002101B3, 32'h10C, 32'h7, 32'h7);
      #1;
      check("lu_if_ready", 32'(if_ready), 32'd0);
      tick();
      check("lu_bubble", 32'(ex_valid), 32'd0);
      check("lu_retry_ready", 32'(if_ready), 32'd1);
      tick();
      check("lu_add_valid", 32'(ex_valid), 32'd1);
      check("lu_add_rd", 32'(ex_rd_addr), 32'd3);
      check("lu_add_pc", ex_pc, 32'h10C);

      // LW x0,0(x1) then ADD x3,x0,x0: no stall
      present(32'h0000A003, 32'h110, 32'h0, 32'h0);
      tick();
      check("lw0_reg_write", 32'(ex_reg_write), 32'd0);
      check("lw0_mem_read", 32'(ex_mem_read), 32'd1);
      present(32'h000001B3, 32'h114, 32'h0, 32'h0);
      #1;
      check("lw0_if_ready", 32'(if_ready), 32'd1);
      tick();
      check("lw0_add_valid", 32'(ex_valid), 32'd1);
      check("lw0_add_rd", 32'(ex_rd_addr), 32'd3);

      // Flush kills the incoming instruction
      present(32'h00500093, 32'h118, 32'h0, 32'h0);
      flush = 1'b1;
      tick();
      check("flush_valid", 32'(ex_valid), 32'd0);
      flush = 1'b0;

      // BEQ x0,x0,-4
      present(32'hFE000EE3, 32'h11C, 32'h0, 32'h0);
      tick();
      check("beq_valid", 32'(ex_valid), 32'd1);
      check("beq_imm", ex_imm, 32'hFFFFFFFC);
      check("beq_branch", 32'(ex_branch), 32'd1);
      check("beq_reg_write", 32'(ex_reg_write), 32'd0);
      check("beq_alu_op", 32'(ex_alu_op), 32'd1);

      // Illegal opcode 0x7F
      present(32'h0000007F, 32'h120, 32'h0, 32'h0);
      tick();
      check("ill_flag", 32'(ex_illegal), 32'd1);
      check("ill_flags", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump},
            32'd0);

      // ADD x0,x1,x2
      present(32'h00208033, 32'h124, 32'h1, 32'h2);
      tick();
      check("addx0_reg_write", 32'(ex_reg_write), 32'd0);
      check("addx0_illegal", 32'(ex_illegal), 32'd0);

      // SRAI x5,x6,3 and LUI x0,0x12345
      present(32'h40335293, 32'h128, 32'h0, 32'h0);
      tick();
      check("srai_imm", ex_imm, 32'd3);
      check("srai_alu_op", 32'(ex_alu_op), 32'd7);
      present(32'h12345037, 32'h12C, 32'h0, 32'h0);
      tick();
      check("lui_imm", ex_imm, 32'h12345000);
      check("lui_alu_op", 32'(ex_alu_op), 32'd10);

      // ADD x4,x1,x0 with a same-cycle writeback to x1
      present(32'h00008233, 32'h130, 32'h11111111, 32'h22222222);
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEADBEEF;
      tick();
`ifdef ID_WB_BYPASS_EN
      check("byp_rs1_val", ex_rs1_val, 32'hDEADBEEF);
`else
      check("byp_rs1_val", ex_rs1_val, 32'h11111111);
`endif
      check("byp_rs2_val", ex_rs2_val, 32'h22222222);
      wb_en = 1'b0;

      // Async reset mid-cycle drops the held instruction immediately
      if_valid = 1'b0;
      ex_ready = 1'b0;
      #2;
      check("pre_arst_valid", 32'(ex_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(ex_valid), 32'd0);
      check("arst_pc", ex_pc, 32'd0);
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
